act_func_pipe_stage: RTL and testbench

- Parametrised successor to the single-shot activation stage in the neuron datapath.
- Sits between the MAC/accumulate stage and the neuron-value register file.
- Applies a selectable activation function to a signed fixed-point value and carries the destination tag along with it.
- Replaces the one-op-then-stall flow with a valid/ready handshake, a 1-cycle compute register and an output FIFO, so back-to-back neuron ops stream at 1 per cycle.

---
 rtl/act_func_pipe_stage_if.sv | 32 +++
 rtl/act_func_pipe_stage.sv | 195 +++++++++++++++++++
 tb/tb_act_func_pipe_stage.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_func_pipe_stage_if.sv
// Stream bundle for act_func_pipe_stage: input valid/ready channel carrying
// value, function select and destination tag, plus the output FIFO head channel.
// master = producer/consumer side (upstream + downstream), slave = the stage.
interface act_func_pipe_stage_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned DEST_W = 16
);

  // Input channel (MAC/accumulate stage -> activation stage)
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] in_val;
  logic [1:0]        in_sel;
  logic [DEST_W-1:0] in_dest;

  // Output channel (activation stage -> neuron-value register file)
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_val;
  logic [DEST_W-1:0] out_dest;

  modport master (
    output in_valid, in_val, in_sel, in_dest, out_ready,
    input  in_ready, out_valid, out_val, out_dest
  );

  modport slave (
    input  in_valid, in_val, in_sel, in_dest, out_ready,
    output in_ready, out_valid, out_val, out_dest
  );

endinterface

// File: rtl/act_func_pipe_stage.sv
// Activation pipe stage: applies identity / ReLU / step / leaky-ReLU to a
// signed fixed-point value, carries the destination tag alongside it, and
// streams results through a 1-cycle compute register and an output FIFO.
// Optional build macro ACT_FUNC_OP_COUNT_EN adds a 16-bit completed-pop
// counter (op_count) with a synchronous clear input (op_count_clr).
module act_func_pipe_stage #(
  parameter int unsigned      DATA_W     = 16,
  parameter int unsigned      DEST_W     = 16,
  parameter int unsigned      FIFO_DEPTH = 4,
  parameter int unsigned      LEAK_SHIFT = 3,
  parameter logic [DATA_W-1:0] ONE_VAL   = DATA_W'(16'h0100)
) (
  input  logic                   clk,
  input  logic                   rst,
  act_func_pipe_stage_if.slave   bus,
  output logic                   finished_op
`ifdef ACT_FUNC_OP_COUNT_EN
  ,
  output logic [15:0]            op_count,
  input  logic                   op_count_clr
`endif
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 2) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {
    SEL_IDENTITY = 2'b00,
    SEL_RELU     = 2'b01,
    SEL_STEP     = 2'b10,
    SEL_LEAKY    = 2'b11
  } sel_e;

  // Compute register
  logic              r_pipe_valid;
  logic [DATA_W-1:0] r_pipe_val;
  logic [DEST_W-1:0] r_pipe_dest;

  // Output FIFO
  logic [DATA_W-1:0] r_mem_val  [FIFO_DEPTH];
  logic [DEST_W-1:0] r_mem_dest [FIFO_DEPTH];
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  logic [DATA_W-1:0] r_out_val;
  logic [DEST_W-1:0] r_out_dest;

  // Misc control
  logic              r_alive;
  logic              r_finished;

  // Combinational nets
  sel_e                     w_sel;
  logic signed [DATA_W-1:0] w_in_s;
  logic signed [DATA_W-1:0] w_leak;
  logic [DATA_W-1:0]        w_act;
  logic                     w_in_ready;
  logic                     w_accept;
  logic                     w_push;
  logic                     w_pop;
  logic                     w_fifo_nonempty;
  logic [PTR_W-1:0]         w_rd_next;

  // Activation function on the incoming value; leaky shift is kept in its own
  // signed net so the ternary below cannot turn it into a logical shift.
  always_comb begin
    w_sel  = sel_e'(bus.in_sel);
    w_in_s = $signed(bus.in_val);
    w_leak = w_in_s >>> LEAK_SHIFT;
    w_act  = bus.in_val;
    unique case (w_sel)
      SEL_IDENTITY: w_act = bus.in_val;
      SEL_RELU:     w_act = w_in_s[DATA_W-1] ? '0 : bus.in_val;
      SEL_STEP:     w_act = (!w_in_s[DATA_W-1] && (bus.in_val != '0)) ? ONE_VAL : '0;
      SEL_LEAKY:    w_act = w_in_s[DATA_W-1] ? w_leak : bus.in_val;
      default:      w_act = bus.in_val;
    endcase
  end

  // Handshake decode; in_ready depends on registers only (no out_ready path).
  always_comb begin
    w_fifo_nonempty = (r_count != '0);
    w_in_ready      = r_alive &&
                      ((32'(r_count) + 32'(r_pipe_valid)) < FIFO_DEPTH);
    w_accept        = bus.in_valid && w_in_ready;
    w_push          = r_pipe_valid;
    w_pop           = w_fifo_nonempty && bus.out_ready;
    w_rd_next       = r_rd_ptr + PTR_W'(1);
  end

  // Ready enable: held low in reset, raised on the first edge after release.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_alive <= 1'b0;
    else      r_alive <= 1'b1;
  end

  // Compute register: captures result + tag on accept, otherwise empties.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pipe_valid <= 1'b0;
      r_pipe_val   <= '0;
      r_pipe_dest  <= '0;
    end else begin
      r_pipe_valid <= w_accept;
      if (w_accept) begin
        r_pipe_val  <= w_act;
        r_pipe_dest <= bus.in_dest;
      end
    end
  end

  // FIFO storage write (no reset needed; occupancy is tracked by r_count).
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_val[r_wr_ptr]  <= r_pipe_val;
      r_mem_dest[r_wr_ptr] <= r_pipe_dest;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= w_rd_next;
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Registered FIFO head. It is loaded with whatever entry will sit at the read
  // pointer after this edge, and holds its value whenever the FIFO goes empty.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_out_val  <= '0;
      r_out_dest <= '0;
    end else if (w_pop) begin
      if (r_count > CNT_W'(1)) begin
        r_out_val  <= r_mem_val[w_rd_next];
        r_out_dest <= r_mem_dest[w_rd_next];
      end else if (w_push) begin
        r_out_val  <= r_pipe_val;
        r_out_dest <= r_pipe_dest;
      end
    end else if (!w_fifo_nonempty && w_push) begin
      r_out_val  <= r_pipe_val;
      r_out_dest <= r_pipe_dest;
    end
  end

  // One-cycle completion pulse following each pop edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_finished <= 1'b0;
    else      r_finished <= w_pop;
  end

`ifdef ACT_FUNC_OP_COUNT_EN
  logic [15:0] r_op_count;

  // Completed-pop counter; a clear that coincides with a pop leaves 1.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_op_count <= '0;
    end else if (op_count_clr) begin
      r_op_count <= w_pop ? 16'd1 : 16'd0;
    end else if (w_pop) begin
      r_op_count <= r_op_count + 16'd1;
    end
  end

  assign op_count = r_op_count;
`endif

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = w_fifo_nonempty;
  assign bus.out_val   = r_out_val;
  assign bus.out_dest  = r_out_dest;
  assign finished_op   = r_finished;

  // Occupancy of pipe + FIFO never exceeds the FIFO depth.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    (32'(r_count) + 32'(r_pipe_valid)) <= FIFO_DEPTH);

  // A stalled head keeps its value and tag.
  a_head_stable: assert property (@(posedge clk) disable iff (!rst)
    (w_fifo_nonempty && !bus.out_ready) |=>
      ($stable(r_out_val) && $stable(r_out_dest)));

endmodule

// File: tb/tb_act_func_pipe_stage.sv
// Bench for act_func_pipe_stage: table vectors, directed corner sequences and
// random traffic checked against a queue-based transaction-level reference.
module tb_act_func_pipe_stage;

  localparam int DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic finished_op;
`ifdef ACT_FUNC_OP_COUNT_EN
  logic [15:0] op_count;
  logic        op_count_clr = 1'b0;
`endif

  act_func_pipe_stage_if #(.DATA_W(16), .DEST_W(16)) bus ();

  act_func_pipe_stage #(
    .DATA_W     (16),
    .DEST_W     (16),
    .FIFO_DEPTH (DEPTH),
    .LEAK_SHIFT (3),
    .ONE_VAL    (16'h0100)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .finished_op (finished_op)
`ifdef ACT_FUNC_OP_COUNT_EN
    ,
    .op_count    (op_count),
    .op_count_clr(op_count_clr)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] val;
    logic [15:0] dest;
    int          vis;
  } item_t;

  typedef struct {
    logic [1:0]  sel;
    logic [15:0] val;
    logic [15:0] exp;
  } vec_t;

  item_t q[$];
  int    cyc = 0;
  int    n_cmp = 0;
  int    n_err = 0;
  bit    prev_pop = 0;
  bit    in_rst = 0;
  int    m_cnt = 0;
  int    dut_acc = 0;
  int    dut_fin = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference activation from the arithmetic definition of each function.
  function automatic logic [15:0] ref_fn(input logic [1:0] sel, input logic [15:0] v);
    int s;
    int r;
    s = int'($signed(v));
    case (sel)
      2'd0:    r = s;
      2'd1:    r = (s < 0) ? 0 : s;
      2'd2:    r = (s > 0) ? 256 : 0;
      default: r = (s < 0) ? -((-s + 7) / 8) : s;   // floor(s / 8)
    endcase
    return r[15:0];
  endfunction

  // One clock of stimulus: drive, compare the pre-edge state, advance the model.
  task automatic cycle(input bit v, input logic [1:0] sel, input logic [15:0] val,
                       input logic [15:0] dest, input bit ordy,
                       input bit has_exp = 0, input logic [15:0] expv = '0);
    bit    exp_ir;
    bit    exp_ov;
    bit    acc;
    bit    pop;
    item_t it;
    bus.in_valid  = v;
    bus.in_sel    = sel;
    bus.in_val    = val;
    bus.in_dest   = dest;
    bus.out_ready = ordy;
    #1;
    exp_ir = !in_rst && (q.size() < DEPTH);
    exp_ov = (q.size() > 0) && (q[0].vis <= cyc);
    chk("in_ready", 32'(bus.in_ready), 32'(exp_ir));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    if (exp_ov) begin
      chk("out_val", 32'(bus.out_val), 32'(q[0].val));
      chk("out_dest", 32'(bus.out_dest), 32'(q[0].dest));
    end
    chk("finished_op", 32'(finished_op), 32'(prev_pop));
`ifdef ACT_FUNC_OP_COUNT_EN
    chk("op_count", 32'(op_count), 32'(m_cnt));
`endif
    if (v && bus.in_ready) dut_acc++;
    if (finished_op) dut_fin++;
    acc = v && exp_ir;
    pop = exp_ov && ordy;
    @(posedge clk);
    cyc++;
`ifdef ACT_FUNC_OP_COUNT_EN
    if (op_count_clr) m_cnt = pop ? 1 : 0;
    else if (pop)     m_cnt = (m_cnt + 1) % 65536;
`endif
    if (pop) void'(q.pop_front());
    if (acc) begin
      it.val  = has_exp ? expv : ref_fn(sel, val);
      it.dest = dest;
      it.vis  = cyc + 1;
      q.push_back(it);
    end
    prev_pop = pop;
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(0, 2'd0, 16'h0, 16'h0, 1);
  endtask

  // Asynchronous reset asserted between edges, released between edges.
  task automatic apply_reset(input bit check_data);
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    q.delete();
    prev_pop = 0;
    m_cnt    = 0;
    in_rst   = 1;
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_finished_op", 32'(finished_op), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    if (check_data) begin
      chk("rst_out_val", 32'(bus.out_val), 32'd0);
      chk("rst_out_dest", 32'(bus.out_dest), 32'd0);
    end
`ifdef ACT_FUNC_OP_COUNT_EN
    chk("rst_op_count", 32'(op_count), 32'd0);
`endif
    @(posedge clk);
    @(posedge clk);
    #1;
    chk("rst_hold_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_hold_out_valid", 32'(bus.out_valid), 32'd0);
    #2;
    rst    = 1'b1;
    in_rst = 0;
    @(posedge clk);
    cyc++;
    #1;
  endtask

  vec_t tbl[9];

  initial begin
    tbl[0] = '{2'b01, 16'hFF00, 16'h0000};
    tbl[1] = '{2'b01, 16'h0300, 16'h0300};
    tbl[2] = '{2'b10, 16'h0005, 16'h0100};
    tbl[3] = '{2'b10, 16'h0000, 16'h0000};
    tbl[4] = '{2'b10, 16'h8000, 16'h0000};
    tbl[5] = '{2'b11, 16'hFF00, 16'hFFE0};
    tbl[6] = '{2'b11, 16'h8000, 16'hF000};
    tbl[7] = '{2'b11, 16'h0040, 16'h0040};
    tbl[8] = '{2'b00, 16'h8000, 16'h8000};

    bus.in_valid  = 1'b0;
    bus.in_sel    = 2'b00;
    bus.in_val    = '0;
    bus.in_dest   = '0;
    bus.out_ready = 1'b0;

    apply_reset(1);

    // Identity with tag pass-through; one finished_op pulse expected
    dut_fin = 0;
    cycle(1, 2'b00, 16'h1234, 16'h0007, 1, 1, 16'h1234);
    idle(4);
    chk("ident_fin_pulses", 32'(dut_fin), 32'd1);

    // Function table, one op per cycle
    for (int i = 0; i < 9; i++)
      cycle(1, tbl[i].sel, tbl[i].val, 16'(16 + i), 1, 1, tbl[i].exp);
    idle(4);

    // Backpressure: 6 offered, 4 taken, then drain in order
    dut_acc = 0;
    for (int i = 0; i < 6; i++)
      cycle(1, 2'b00, 16'(16'h0A00 + i), 16'(i), 0);
    chk("bp_accepts", 32'(dut_acc), 32'd4);
    chk("bp_in_ready_low", 32'(bus.in_ready), 32'd0);
    dut_fin = 0;
    idle(7);
    chk("bp_fin_pulses", 32'(dut_fin), 32'd4);
    chk("bp_in_ready_back", 32'(bus.in_ready), 32'd1);

    // Streaming at one op per cycle
    dut_acc = 0;
    dut_fin = 0;
    for (int i = 0; i < 20; i++)
      cycle(1, 2'($urandom_range(0, 3)), 16'($urandom), 16'(100 + i), 1);
    chk("stream_accepts", 32'(dut_acc), 32'd20);
    idle(4);
    chk("stream_fin_pulses", 32'(dut_fin), 32'd20);

    // Reset mid-stream with three entries queued and a pulse in flight
    for (int i = 0; i < 4; i++)
      cycle(1, 2'b00, 16'(16'h0B00 + i), 16'(200 + i), 0);
    cycle(0, 2'b00, 16'h0, 16'h0, 1);
    apply_reset(0);
    dut_fin = 0;
    cycle(1, 2'b01, 16'h0050, 16'h00AA, 1);
    idle(4);
    chk("post_rst_single", 32'(dut_fin), 32'd1);

    // Random traffic
    for (int i = 0; i < 400; i++)
      cycle(bit'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 16'($urandom),
            16'($urandom), ($urandom_range(0, 3) != 0));
    idle(6);

`ifdef ACT_FUNC_OP_COUNT_EN
    apply_reset(0);
    for (int i = 0; i < 5; i++)
      cycle(1, 2'b00, 16'(i), 16'(i), 1);
    idle(3);
    chk("opcnt_five", 32'(op_count), 32'd5);

    cycle(1, 2'b00, 16'h0001, 16'h0001, 0);
    cycle(0, 2'b00, 16'h0, 16'h0, 0);
    op_count_clr = 1'b1;
    cycle(0, 2'b00, 16'h0, 16'h0, 1);
    op_count_clr = 1'b0;
    idle(1);
    chk("opcnt_clr_pop", 32'(op_count), 32'd1);

    for (int i = 0; i < 65535; i++)
      cycle(1, 2'b00, 16'(i), 16'(i), 1);
    idle(3);
    chk("opcnt_wrap", 32'(op_count), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
